oam_scan: RTL and testbench
===========================

Name: oam_scan

Overview:
- Per-line sprite evaluator for the PPU.
- On a start pulse at the beginning of mode 2 it walks OAM and selects up to LINE_MAX sprites that intersect the current line, in ascending OAM order.
- For each selected sprite it latches X, the effective tile and row (Y-flip and 8x16 mode resolved), and the attributes into a small line buffer.
- The sprite fetch stage in mode 3 reads that buffer through a random-access port.

Parameters:
SPRITE_COUNT, 40, number of OAM entries scanned (4 bytes each)
LINE_MAX, 10, maximum sprites stored per line
OAM_AW, 8, OAM byte address width (must hold 4*SPRITE_COUNT-1)
IDX_W, 4, width of count/sel_index (must hold LINE_MAX)

Ports:
clockgb  in  1  single clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; samples line, tall, enable
line  in  8  current LY
tall  in  1  1 = 8x16 sprites
enable  in  1  sprite enable; 0 = empty scan
oam_rd  out  1  OAM read strobe
oam_addr  out  OAM_AW  OAM byte address
oam_data  in  8  read data, valid the cycle after oam_rd
busy  out  1  scan in progress
done  out  1  one-cycle pulse, scan complete
count  out  IDX_W  sprites stored this line
overflow  out  1  more than LINE_MAX hits seen; held until next start
sel_index  in  IDX_W  buffer read index
sel_oam  out  6  OAM index of entry
sel_x  out  8  raw OAM X byte
sel_tile  out  8  effective tile number
sel_row  out  3  effective row within tile (0..7)
sel_attr  out  8  raw attribute byte

Behaviour:
- Reset (any time, including mid-scan):
  - FSM returns to IDLE.
  - oam_rd, busy, done, overflow and count are 0.
  - All buffer entries are cleared to 0.
- States: IDLE, YCHK, XCHK, TCHK, ACHK, FIN. Start is sampled in the cycle it is high (cycle 0).
- enable=0 at start: no OAM reads; count=0; done pulses in cycle 1; busy stays 0.
- enable=1 at start:
  - Clears count and overflow; busy=1 from cycle 1.
  - Cycle 1: oam_rd=1, oam_addr=0 (Y of sprite 0); state YCHK.
- YCHK (oam_data = Y of sprite i):
  - diff = {0,line} + 16 - {0,Y}, 9-bit unsigned.
  - hit = diff < (tall ? 16 : 8).
  - If hit and count<LINE_MAX: latch diff[3:0] and i; read 4i+1; go to XCHK.
  - If hit and count==LINE_MAX: set overflow; no store.
  - Non-stored sprite (miss, or hit with the buffer full): if i<SPRITE_COUNT-1, read 4(i+1) and stay in YCHK; else go to FIN.
- XCHK: latch X; read 4i+2; go to TCHK.
- TCHK: latch tile; read 4i+3; go to ACHK.
- ACHK (attr): compute and store the entry at index count, increment count, then read the next Y or go to FIN.
  - r = attr[6] ? (h-1-diff[3:0]) : diff[3:0], with h=16 if tall, else 8.
  - tall: sel_tile = {tile[7:1], r[3]}.
  - not tall: sel_tile = tile.
  - sel_row = r[2:0].
- FIN: done=1 for one cycle; busy=0; return to IDLE.
- Timing: done is asserted in cycle 2+SPRITE_COUNT+3*S, where S = sprites stored. For defaults the worst case is cycle 72, inside the 80-cycle mode 2.
- oam_rd is high exactly in cycles that issue a read; oam_addr is don't-care otherwise.
- Buffer read port is combinational on sel_index.
  - Returns the stored entry if sel_index<count; returns all zeros otherwise.
  - Entries are valid once written, including mid-scan.
- start while busy: aborts the current scan and restarts from sprite 0 with the new inputs. The aborted scan produces no done; count and overflow are cleared.
- count and buffer contents hold after done until the next start or reset.
- All arithmetic is modulo-9-bit as stated. Y=0 and Y>=line+16+h never hit; line 0 hits Y=9..16 (8x8).

Test Plan:
- Empty OAM (all Y=0), line=50, tall=0: 40 reads (addr 0,4,...,156), done at cycle 42, count=0, overflow=0.
- Sprite 3 Y=66 X=20 tile=0x45 attr=0x00, line=55, tall=0: diff=5 hit; count=1; sel_index=0 gives sel_oam=3, sel_x=20, sel_tile=0x45, sel_row=5; done at cycle 45.
- Same sprite with attr=0x40, tall=1, line=55: r=15-5=10; sel_tile=0x45, sel_row=2. With attr=0x00: sel_tile=0x44, sel_row=5.
- 12 sprites all Y=16, line=0: count=10 (OAM 0..9), overflow=1, done at cycle 72; sel_index=10 reads zeros.
- enable=0 with hits present: no oam_rd, done at cycle 1, count=0. Then start again with enable=1 at line 0: the hits are found.
- Reset asserted at cycle 20 of the 12-sprite scan: busy, oam_rd, count and overflow go to 0 immediately, and no done follows. A restart then completes normally.
- start re-pulsed at cycle 30 with line=100 (no hits): count=0, single done at cycle 72 (30+42).

Source files
------------

// File: rtl/oam_scan.sv
// oam_scan: per-line OAM sprite evaluator feeding a random-access line buffer
// Ports: clockgb/reset (async, active-high); start samples line, tall, enable;
//   oam_rd/oam_addr out, oam_data in (valid one cycle after oam_rd);
//   busy, done, count, overflow report scan status;
//   sel_index selects a buffer entry returned on sel_oam/sel_x/sel_tile/sel_row/sel_attr.
module oam_scan #(
    parameter int SPRITE_COUNT = 40,
    parameter int LINE_MAX     = 10,
    parameter int OAM_AW       = 8,
    parameter int IDX_W        = 4
) (
    input  logic              clockgb,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        line,
    input  logic              tall,
    input  logic              enable,
    output logic              oam_rd,
    output logic [OAM_AW-1:0] oam_addr,
    input  logic [7:0]        oam_data,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  count,
    output logic              overflow,
    input  logic [IDX_W-1:0]  sel_index,
    output logic [5:0]        sel_oam,
    output logic [7:0]        sel_x,
    output logic [7:0]        sel_tile,
    output logic [2:0]        sel_row,
    output logic [7:0]        sel_attr
);
    typedef enum logic [2:0] {IDLE, YCHK, XCHK, TCHK, ACHK, FIN} state_t;
    localparam logic [5:0]       LAST = 6'(SPRITE_COUNT - 1);
    localparam logic [IDX_W-1:0] FULL = IDX_W'(LINE_MAX);
    state_t state, state_nx;
    logic [5:0] idx, idx_nx;
    logic first;
    logic [7:0] line_q, x_q, tile_q;
    logic tall_q;
    logic [3:0] dy, r;
    logic [8:0] diff;
    logic hit, room, last, valid;
    logic [5:0] b_oam [LINE_MAX];
    logic [7:0] b_x [LINE_MAX];
    logic [7:0] b_tile [LINE_MAX];
    logic [2:0] b_row [LINE_MAX];
    logic [7:0] b_attr [LINE_MAX];

    function automatic logic [OAM_AW-1:0] byte_addr(input logic [5:0] n, input logic [1:0] f);
        return OAM_AW'({n, f});
    endfunction

    // Reads are issued combinationally so each state consumes the byte it
    // requested one cycle earlier; 'first' marks the cycle that only issues
    // the Y read of sprite 0 and has no valid data to evaluate yet.
    always_comb begin
        diff = {1'b0, line_q} + 9'd16 - {1'b0, oam_data};
        hit = !first && diff < (tall_q ? 9'd16 : 9'd8);
        room = count < FULL;
        last = idx == LAST;
        r = oam_data[6] ? (tall_q ? 4'd15 : 4'd7) - dy : dy;
        state_nx = state;
        idx_nx = idx;
        oam_rd = 1'b0;
        oam_addr = '0;
        case (state)
            YCHK: begin
                if (first) begin
                    oam_rd = 1'b1;
                    oam_addr = byte_addr(idx, 2'd0);
                end else if (hit && room) begin
                    state_nx = XCHK;
                    oam_rd = 1'b1;
                    oam_addr = byte_addr(idx, 2'd1);
                end else if (!last) begin
                    idx_nx = idx + 6'd1;
                    oam_rd = 1'b1;
                    oam_addr = byte_addr(idx + 6'd1, 2'd0);
                end else begin
                    state_nx = FIN;
                end
            end
            XCHK: begin
                state_nx = TCHK;
                oam_rd = 1'b1;
                oam_addr = byte_addr(idx, 2'd2);
            end
            TCHK: begin
                state_nx = ACHK;
                oam_rd = 1'b1;
                oam_addr = byte_addr(idx, 2'd3);
            end
            ACHK: begin
                if (!last) begin
                    state_nx = YCHK;
                    idx_nx = idx + 6'd1;
                    oam_rd = 1'b1;
                    oam_addr = byte_addr(idx + 6'd1, 2'd0);
                end else begin
                    state_nx = FIN;
                end
            end
            FIN: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (start) begin
            state_nx = enable ? YCHK : FIN;
            idx_nx = '0;
            oam_rd = 1'b0;
        end
    end

    always_ff @(posedge clockgb or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx <= '0;
            first <= 1'b0;
            line_q <= '0;
            tall_q <= 1'b0;
            dy <= '0;
            x_q <= '0;
            tile_q <= '0;
            count <= '0;
            overflow <= 1'b0;
            for (int k = 0; k < LINE_MAX; k++) begin
                b_oam[k] <= '0;
                b_x[k] <= '0;
                b_tile[k] <= '0;
                b_row[k] <= '0;
                b_attr[k] <= '0;
            end
        end else begin
            state <= state_nx;
            idx <= idx_nx;
            first <= start && enable;
            if (start) begin
                line_q <= line;
                tall_q <= tall;
                count <= '0;
                overflow <= 1'b0;
            end else begin
                if (state == YCHK && hit) begin
                    if (room) dy <= diff[3:0];
                    else overflow <= 1'b1;
                end
                if (state == XCHK) x_q <= oam_data;
                if (state == TCHK) tile_q <= oam_data;
                if (state == ACHK) begin
                    b_oam[count] <= idx;
                    b_x[count] <= x_q;
                    b_tile[count] <= tall_q ? {tile_q[7:1], r[3]} : tile_q;
                    b_row[count] <= r[2:0];
                    b_attr[count] <= oam_data;
                    count <= count + IDX_W'(1);
                end
            end
        end
    end

    always_comb begin
        valid = sel_index < count;
        sel_oam = valid ? b_oam[sel_index] : '0;
        sel_x = valid ? b_x[sel_index] : '0;
        sel_tile = valid ? b_tile[sel_index] : '0;
        sel_row = valid ? b_row[sel_index] : '0;
        sel_attr = valid ? b_attr[sel_index] : '0;
    end

    assign busy = state inside {YCHK, XCHK, TCHK, ACHK};
    assign done = state == FIN;
endmodule

// File: tb/tb_oam_scan.sv
// tb_oam_scan: randomized scoreboard bench for oam_scan against a per-line sprite model
module tb_oam_scan;
    localparam int N = 40;
    localparam int LM = 10;

    typedef struct {
        int t0;
        int lat;
        int cnt;
        bit ovf;
        int na;
        int addr [160];
        logic [32:0] ent [LM];
    } exp_t;

    logic clockgb = 0, reset = 1, start = 0, tall = 0, enable = 0;
    logic [7:0] line = 0;
    logic oam_rd, busy, done, overflow;
    logic [7:0] oam_addr, oam_data;
    logic [3:0] count, sel_index;
    logic [5:0] sel_oam;
    logic [7:0] sel_x, sel_tile, sel_attr;
    logic [2:0] sel_row;

    oam_scan dut (
        .clockgb(clockgb), .reset(reset), .start(start), .line(line), .tall(tall),
        .enable(enable), .oam_rd(oam_rd), .oam_addr(oam_addr), .oam_data(oam_data),
        .busy(busy), .done(done), .count(count), .overflow(overflow),
        .sel_index(sel_index), .sel_oam(sel_oam), .sel_x(sel_x), .sel_tile(sel_tile),
        .sel_row(sel_row), .sel_attr(sel_attr)
    );

    always #20 clockgb = ~clockgb;

    int cyc = 0;
    always @(posedge clockgb) cyc <= cyc + 1;

    logic [7:0] mem [256];
    always @(posedge clockgb) oam_data <= oam_rd ? mem[oam_addr] : 8'($urandom);

    int rd_c [$];
    int rd_a [$];
    always @(negedge clockgb) if (oam_rd) begin
        rd_c.push_back(cyc);
        rd_a.push_back(int'(oam_addr));
    end

    exp_t q [$];
    int errors = 0, checks = 0;

    task automatic chk(input bit ok, input string nm, input longint got, input longint want);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    // Reference: scan sprites in OAM order, a sprite covers lines Y-16 .. Y-16+h-1.
    function automatic exp_t model(input int ln, input bit tl, input bit en);
        exp_t e;
        int h, d, rr;
        logic [7:0] x, tile, attr, te;
        h = tl ? 16 : 8;
        e.cnt = 0;
        e.ovf = 0;
        e.na = 0;
        e.t0 = 0;
        for (int k = 0; k < LM; k++) e.ent[k] = '0;
        if (!en) begin
            e.lat = 1;
            return e;
        end
        for (int i = 0; i < N; i++) begin
            e.addr[e.na] = 4 * i;
            e.na = e.na + 1;
            d = ln + 16 - int'(mem[4 * i]);
            if (d >= 0 && d < h) begin
                if (e.cnt < LM) begin
                    for (int f = 1; f < 4; f++) begin
                        e.addr[e.na] = 4 * i + f;
                        e.na = e.na + 1;
                    end
                    x = mem[4 * i + 1];
                    tile = mem[4 * i + 2];
                    attr = mem[4 * i + 3];
                    rr = attr[6] ? h - 1 - d : d;
                    te = tl ? {tile[7:1], rr >= 8} : tile;
                    e.ent[e.cnt] = {6'(i), x, te, 3'(rr % 8), attr};
                    e.cnt = e.cnt + 1;
                end else begin
                    e.ovf = 1;
                end
            end
        end
        e.lat = 2 + N + 3 * e.cnt;
        return e;
    endfunction

    // Monitor: every done pulse is matched against the oldest pending expectation.
    initial begin
        exp_t e;
        int j;
        bit bad;
        logic [32:0] got, want;
        sel_index = 0;
        forever begin
            @(negedge clockgb);
            if (done) begin
                chk(q.size() > 0, "done_expected", q.size(), 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk(cyc - e.t0 == e.lat, "done_cycle", cyc - e.t0, e.lat);
                    chk(count == 4'(e.cnt), "count", count, e.cnt);
                    chk(overflow == e.ovf, "overflow", overflow, e.ovf);
                    chk(!busy, "busy_at_done", busy, 0);
                    j = 0;
                    bad = 0;
                    for (int k = 0; k < rd_c.size(); k++) begin
                        if (rd_c[k] > e.t0 && rd_c[k] <= cyc) begin
                            if (j >= e.na || rd_a[k] != e.addr[j]) bad = 1;
                            j++;
                        end
                    end
                    chk(!bad && j == e.na, "read_sequence", j, e.na);
                    rd_c.delete();
                    rd_a.delete();
                    for (int k = 0; k <= LM; k++) begin
                        sel_index = 4'(k);
                        #1;
                        got = {sel_oam, sel_x, sel_tile, sel_row, sel_attr};
                        want = k < e.cnt ? e.ent[k] : '0;
                        chk(got == want, $sformatf("entry%0d", k), got, want);
                    end
                end
            end
        end
    end

    // Called at a negedge; leaves the bench at the negedge of cycle 1.
    task automatic do_start(input int ln, input bit tl, input bit en);
        exp_t e;
        q = {};
        e = model(ln, tl, en);
        e.t0 = cyc;
        q.push_back(e);
        line = 8'(ln);
        tall = tl;
        enable = en;
        start = 1;
        @(negedge clockgb);
        start = 0;
    endtask

    task automatic wait_done();
        for (int n = 0; n < 300 && !done; n++) @(negedge clockgb);
        chk(done, "done_timeout", done, 1);
        repeat (3) @(negedge clockgb);
    endtask

    task automatic run(input int ln, input bit tl, input bit en);
        do_start(ln, tl, en);
        wait_done();
    endtask

    task automatic clear_mem();
        for (int k = 0; k < 256; k++) mem[k] = 8'h00;
    endtask

    task automatic twelve();
        clear_mem();
        for (int i = 0; i < 12; i++) begin
            mem[4 * i] = 8'd16;
            mem[4 * i + 1] = 8'(i + 8);
            mem[4 * i + 2] = 8'(i * 3);
            mem[4 * i + 3] = 8'(i * 16);
        end
    endtask

    initial begin
        clear_mem();
        repeat (3) @(negedge clockgb);
        #1;
        chk({busy, done, oam_rd, overflow, count} == '0, "reset_state", {busy, done, oam_rd, overflow, count}, 0);
        reset = 0;
        @(negedge clockgb);
        chk({busy, done, oam_rd, overflow, count, sel_oam, sel_x, sel_tile, sel_row, sel_attr} == '0,
            "after_reset", {busy, done, oam_rd, overflow, count}, 0);

        run(50, 0, 1);

        mem[12] = 8'd66; mem[13] = 8'd20; mem[14] = 8'h45; mem[15] = 8'h00;
        run(55, 0, 1);
        mem[15] = 8'h40;
        run(55, 1, 1);
        mem[15] = 8'h00;
        run(55, 1, 1);

        twelve();
        run(0, 0, 1);
        run(0, 0, 0);
        chk(rd_c.size() == 0, "no_reads_disabled", rd_c.size(), 0);
        run(0, 0, 1);

        do_start(0, 0, 1);
        repeat (19) @(negedge clockgb);
        reset = 1;
        #1;
        chk({busy, done, oam_rd, overflow, count} == '0, "reset_midscan", {busy, done, oam_rd, overflow, count}, 0);
        q = {};
        repeat (2) @(negedge clockgb);
        reset = 0;
        repeat (60) @(negedge clockgb);
        run(0, 0, 1);

        do_start(0, 0, 1);
        repeat (29) @(negedge clockgb);
        do_start(100, 0, 1);
        wait_done();

        for (int t = 0; t < 20; t++) begin
            int ln;
            ln = $urandom_range(0, 153);
            for (int i = 0; i < N; i++) begin
                mem[4 * i] = $urandom_range(0, 1) ? 8'(ln + 16 - $urandom_range(0, 17)) : 8'($urandom);
                mem[4 * i + 1] = 8'($urandom);
                mem[4 * i + 2] = 8'($urandom);
                mem[4 * i + 3] = 8'($urandom);
            end
            run(ln, 1'($urandom_range(0, 1)), $urandom_range(0, 15) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
